// File: rtl/m_ext_pkg.sv
// Shared types and helpers for the M-extension datapath blocks.
package m_ext_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_e;

    localparam int DIV_WIDTH_DEF = 32;

    // Counter width needed to hold the value WIDTH (iteration count).
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] rem_t;

    // The shifted partial remainder keeps its top bit so divisors >= 2^(WIDTH-1)
    // still compare correctly; the difference always fits back into WIDTH bits.
    always_comb begin
        rem_t = {rem_in, q_in[WIDTH-1]};
        if (rem_t >= {1'b0, divisor}) begin
            rem_out = rem_t[WIDTH-1:0] - divisor;
            q_out   = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = rem_t[WIDTH-1:0];
            q_out   = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock.
module seq_divider
    import m_ext_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic             dbz,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = div_cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] wrem_q, wrem_d;
    logic [WIDTH-1:0] wquo_q, wquo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (wrem_q),
        .q_in    (wquo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_out   (step_quo)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            wrem_q  <= '0;
            wquo_q  <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrem_q  <= wrem_d;
            wquo_q  <= wquo_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state logic. Working registers iterate privately; the visible
    // results are only written on completion so an aborted op leaves them alone.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrem_d  = wrem_q;
        wquo_d  = wquo_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            DIV_IDLE: begin
                if (start && !flush) begin
                    if (divisor == '0) begin
                        state_d = DIV_DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = DIV_CALC;
                        cnt_d   = CNT_W'(WIDTH);
                        wrem_d  = '0;
                        wquo_d  = dividend;
                        dvs_d   = divisor;
                        dbz_d   = 1'b0;
                    end
                end
            end
            DIV_CALC: begin
                wrem_d = step_rem;
                wquo_d = step_quo;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DIV_DONE;
                    quo_d   = step_quo;
                    rem_d   = step_rem;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        // Flush overrides everything, including a completion on this same edge.
        if (flush) begin
            state_d = DIV_IDLE;
            quo_d   = quo_q;
            rem_d   = rem_q;
            dbz_d   = 1'b0;
        end
    end

    // Outputs decoded from state and result registers.
    always_comb begin
        busy      = (state_q == DIV_CALC);
        valid     = (state_q == DIV_DONE);
        dbz       = dbz_q;
        quotient  = quo_q;
        remainder = rem_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands
// compared against plain a/b, a%b arithmetic.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, valid, dbz;
    logic [W-1:0] quotient, remainder;

    int nvec = 0;
    int nerr = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .valid     (valid),
        .dbz       (dbz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op with a one-cycle start pulse, scramble the operand inputs
    // after acceptance, then check result, latency and pulse width.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq, er;
        int busy_n, lat;
        bit seen;
        eq = (b == 0) ? '1 : a / b;
        er = (b == 0) ? a : a % b;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        busy_n = 0;
        lat    = 0;
        seen   = 1'b0;
        for (int k = 1; k <= W + 5 && !seen; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (valid) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        chk("valid_seen", W'(seen), W'(1));
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("dbz", W'(dbz), W'(b == 0));
        chk("latency", W'(lat), (b == 0) ? W'(1) : W'(W + 1));
        chk("busy_cycles", W'(busy_n), (b == 0) ? W'(0) : W'(W));
        @(negedge clk);
        chk("valid_pulse", W'(valid), W'(0));
    endtask

    initial begin
        int vcount;
        int sel;
        logic [W-1:0] a, b;
        bit seen;

        // Reset values
        #12;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_valid", W'(valid), W'(0));
        chk("rst_dbz", W'(dbz), W'(0));
        chk("rst_q", quotient, '0);
        chk("rst_r", remainder, '0);
        @(negedge clk);
        rst = 1'b0;

        // Basic and boundary operands
        run_op(32'd100, 32'd7);
        run_op(32'hFFFF_FFFF, 32'd1);
        run_op(32'd5, 32'd9);
        run_op(32'h1234, 32'd0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'h7FFF_FFFF, 32'h8000_0000);

        // dbz is cleared by flush
        run_op(32'h55, 32'd0);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_dbz", W'(dbz), W'(0));

        // Flush mid-CALC: prior results kept, no valid
        run_op(32'd100, 32'd7);
        @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_flush_busy", W'(busy), W'(1));
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", W'(busy), W'(0));
        chk("flush_valid", W'(valid), W'(0));
        chk("flush_q_kept", quotient, 32'd14);
        chk("flush_r_kept", remainder, 32'd2);
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid || busy) vcount++;
        end
        chk("flush_no_valid", W'(vcount), W'(0));
        run_op(32'd50, 32'd3);

        // flush and start together: flush wins
        @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd2;
        start    = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("fs_busy", W'(busy), W'(0));
        chk("fs_valid", W'(valid), W'(0));
        chk("fs_q", quotient, 32'd16);

        // start held high with operands changing during CALC
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        seen     = 1'b0;
        for (int k = 0; k < W + 5 && !seen; k++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
            else begin
                dividend = $urandom;
                divisor  = $urandom | 32'd1;
            end
        end
        chk("held_valid_seen", W'(seen), W'(1));
        chk("held_q", quotient, 32'd100);
        chk("held_r", remainder, 32'd0);
        dividend = 32'd77;
        divisor  = 32'd5;
        @(negedge clk);
        chk("held_idle_busy", W'(busy), W'(0));
        chk("held_idle_valid", W'(valid), W'(0));
        @(negedge clk);
        chk("held_second_busy", W'(busy), W'(1));
        start = 1'b0;

        // Asynchronous reset mid-CALC
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", W'(busy), W'(0));
        chk("arst_valid", W'(valid), W'(0));
        chk("arst_dbz", W'(dbz), W'(0));
        chk("arst_q", quotient, '0);
        chk("arst_r", remainder, '0);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid || busy) vcount++;
        end
        chk("arst_no_valid", W'(vcount), W'(0));

        // Random operands, biased toward interesting corners
        for (int i = 0; i < 800; i++) begin
            sel = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            case (sel)
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: a = W'($urandom_range(0, 255));
                3: b = b | 32'h8000_0000;
                4: a = b;
                default: ;
            endcase
            run_op(a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
